instruction_dispatch_control: RTL
=================================

Name: instruction_dispatch_control

Overview:
- Sequences the three control units (weight, matrix-multiply, activation) from a single in-order instruction stream.
- Accepts one instruction at a time with a valid/ready handshake and decodes its class. It holds the instruction until the structural and data hazards against the target unit clear, then issues a one-cycle enable to that unit.
- Also executes SYNC (drain all units) and HALT, and keeps stall and issue statistics for the host.

Parameters:
- STALL_COUNT_WIDTH, 32, width of the saturating stall-cycle and issue counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  global clock enable; when 0 all state holds.
- instr  input  INSTRUCTION_TYPE  incoming instruction.
- instr_valid  input  1  instr is valid.
- instr_ready  output  1  dispatcher accepts instr this cycle.
- weight_instr, matmul_instr, act_instr  output  INSTRUCTION_TYPE  instruction to each unit; all three carry the held register.
- weight_en, matmul_en, act_en  output  1  one-cycle issue strobe per unit.
- weight_busy, matmul_busy, act_busy  input  1  unit is still consuming its instruction.
- weight_resource_busy, matmul_resource_busy, act_resource_busy  input  1  unit pipeline not yet drained.
- halted  output  1  HALT retired; sticky until rst.
- illegal_op  output  1  sticky flag: an undecodable opcode was dropped.
- busy  output  1  dispatcher non-idle or any unit resource_busy.
- stall_cycles  output  STALL_COUNT_WIDTH  saturating count of hazard/sync wait cycles.
- issued_count  output  STALL_COUNT_WIDTH  saturating count of issued unit instructions.

Behaviour:
- Reset: rst=1 has priority over enable.
  - state=IDLE.
  - instr_ready=0 during rst.
  - All *_en=0; *_instr=0.
  - halted=0, illegal_op=0, stall_cycles=0, issued_count=0.
- enable=0: state, holding register and counters freeze; *_en forced 0; instr_ready forced 0.
- instr_ready=1 only in IDLE with enable=1 and halted=0. The handshake fires when instr_valid&instr_ready; instr is latched into the holding register and state goes to DECODE.
- Decode on op_code[7:0]:
  - 8'h00: NOP.
  - 8'hFF: SYNC.
  - 8'hFE: HALT.
  - op_code[7:5]=3'b010: WEIGHT.
  - op_code[7:5]=3'b001: MATMUL.
  - op_code[7:5]=3'b101: ACT. op_code[4:0] passes through untouched.
  - Anything else is illegal.
- Issue conditions are evaluated in DECODE each cycle.
  - WEIGHT: weight_busy=0.
  - MATMUL: matmul_busy=0, weight_busy=0, act_resource_busy=0. Weights must be loaded, and the buffer must have no pending activation writes.
  - ACT: act_busy=0, matmul_resource_busy=0. Accumulators must be final.
- When the condition is met, assert the unit *_en for exactly one cycle, increment issued_count, and go to IDLE the next cycle.
  - Minimum accept-to-issue latency is 1 cycle (issue in the cycle after the handshake).
  - Maximum throughput is 1 instruction per 2 cycles.
- When the condition is not met, stay in DECODE, increment stall_cycles, and keep *_en=0.
- NOP and illegal opcodes: return to IDLE the next cycle with no issue. Illegal also sets illegal_op.
- SYNC: state=SYNC. Stay while any *_busy or *_resource_busy is 1, counting stall_cycles. Return to IDLE in the cycle after all six inputs are 0. A SYNC with everything already idle costs 1 cycle in SYNC.
- HALT: state=HALTED, halted=1, instr_ready=0 permanently until rst.
- Counters saturate at all-ones and never wrap.
- *_instr are driven from the holding register at all times, so they are stable around the *_en strobe.
- busy = (state!=IDLE) | weight_resource_busy | matmul_resource_busy | act_resource_busy.
- Reset mid-DECODE or mid-SYNC discards the held instruction; no *_en pulse is produced.
- Simultaneous events:
  - instr_valid in DECODE/SYNC is not accepted (instr_ready=0).
  - A hazard clearing in the same cycle as enable falling yields no issue that cycle.
- State encoding: IDLE, DECODE, SYNC, HALTED. No other states.

Test Plan:
- Reset, then instr_valid with op 8'h40 and all units idle -> instr_ready=1 in cycle 0; weight_en=1 in cycle 1 only; issued_count=1; instr_ready=1 in cycle 2.
- MATMUL (8'h20) issued while weight_busy=1 for 5 cycles -> matmul_en held 0 for 5 cycles, pulses in the cycle weight_busy is first 0; stall_cycles=5.
- ACT (8'hA3) while matmul_resource_busy=1 for 20 cycles -> no act_en for 20 cycles, then act_en with act_instr.op_code=8'hA3; stall_cycles=20.
- SYNC with act_resource_busy=1 for 10 cycles, followed by WEIGHT -> SYNC held 10 cycles, then IDLE; WEIGHT accepted only after SYNC exits.
- Opcode 8'h60 (illegal) then 8'hFE (HALT) -> illegal_op=1, no *_en pulses; halted=1 and instr_ready stuck at 0; rst clears both.
- enable=0 for 3 cycles during a DECODE with no hazards -> no issue during the freeze; *_en pulses exactly once in the first enabled cycle; counters unchanged while frozen.

Source files
------------

// File: rtl/instruction_dispatch_control.sv
// Instruction dispatch controller: accepts one in-order instruction at a time,
// holds it until the target unit's hazards clear, then strobes that unit.
// Also runs SYNC (drain every unit) and HALT, and keeps stall/issue statistics.

package instruction_dispatch_pkg;
  typedef struct packed {
    logic [7:0]  op_code;
    logic [23:0] operand;
  } INSTRUCTION_TYPE;
endpackage

module instruction_dispatch_control
  import instruction_dispatch_pkg::*;
#(
  parameter int STALL_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  INSTRUCTION_TYPE              instr,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  output INSTRUCTION_TYPE              weight_instr,
  output INSTRUCTION_TYPE              matmul_instr,
  output INSTRUCTION_TYPE              act_instr,
  output logic                         weight_en,
  output logic                         matmul_en,
  output logic                         act_en,
  input  logic                         weight_busy,
  input  logic                         matmul_busy,
  input  logic                         act_busy,
  input  logic                         weight_resource_busy,
  input  logic                         matmul_resource_busy,
  input  logic                         act_resource_busy,
  output logic                         halted,
  output logic                         illegal_op,
  output logic                         busy,
  output logic [STALL_COUNT_WIDTH-1:0] stall_cycles,
  output logic [STALL_COUNT_WIDTH-1:0] issued_count
);

  typedef enum logic [1:0] {IDLE, DECODE, SYNC, HALTED} state_t;
  typedef enum logic [2:0] {
    CLS_NOP, CLS_SYNC, CLS_HALT, CLS_WEIGHT, CLS_MATMUL, CLS_ACT, CLS_ILLEGAL
  } op_class_t;

  localparam logic [STALL_COUNT_WIDTH-1:0] CNT_ONE = {{(STALL_COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STALL_COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                       state_q, state_d;
  INSTRUCTION_TYPE              instr_q, instr_d;
  logic                         halted_q, halted_d;
  logic                         illegal_q, illegal_d;
  logic [STALL_COUNT_WIDTH-1:0] stall_q, stall_d;
  logic [STALL_COUNT_WIDTH-1:0] issued_q, issued_d;
  logic                         stall_inc, issue_inc;
  op_class_t                    op_class;
  logic                         any_unit_active;

  assign any_unit_active = weight_busy | matmul_busy | act_busy |
                           weight_resource_busy | matmul_resource_busy | act_resource_busy;

  // Classify the held opcode; the fixed encodings win over the class prefixes.
  always_comb begin
    op_class = CLS_ILLEGAL;
    if (instr_q.op_code == 8'h00)              op_class = CLS_NOP;
    else if (instr_q.op_code == 8'hFF)         op_class = CLS_SYNC;
    else if (instr_q.op_code == 8'hFE)         op_class = CLS_HALT;
    else if (instr_q.op_code[7:5] == 3'b010)   op_class = CLS_WEIGHT;
    else if (instr_q.op_code[7:5] == 3'b001)   op_class = CLS_MATMUL;
    else if (instr_q.op_code[7:5] == 3'b101)   op_class = CLS_ACT;
  end

  // Next-state, handshake and issue strobes; nothing moves while frozen or in reset.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    stall_inc   = 1'b0;
    issue_inc   = 1'b0;
    instr_ready = 1'b0;
    weight_en   = 1'b0;
    matmul_en   = 1'b0;
    act_en      = 1'b0;
    if (enable && !rst) begin
      case (state_q)
        IDLE: begin
          instr_ready = !halted_q;
          if (instr_valid && !halted_q) begin
            instr_d = instr;
            state_d = DECODE;
          end
        end
        DECODE: begin
          case (op_class)
            CLS_NOP:  state_d = IDLE;
            CLS_SYNC: state_d = SYNC;
            CLS_HALT: begin
              state_d  = HALTED;
              halted_d = 1'b1;
            end
            CLS_WEIGHT: begin
              if (!weight_busy) begin
                weight_en = 1'b1;
                issue_inc = 1'b1;
                state_d   = IDLE;
              end else begin
                stall_inc = 1'b1;
              end
            end
            CLS_MATMUL: begin
              if (!matmul_busy && !weight_busy && !act_resource_busy) begin
                matmul_en = 1'b1;
                issue_inc = 1'b1;
                state_d   = IDLE;
              end else begin
                stall_inc = 1'b1;
              end
            end
            CLS_ACT: begin
              if (!act_busy && !matmul_resource_busy) begin
                act_en    = 1'b1;
                issue_inc = 1'b1;
                state_d   = IDLE;
              end else begin
                stall_inc = 1'b1;
              end
            end
            default: begin
              illegal_d = 1'b1;
              state_d   = IDLE;
            end
          endcase
        end
        SYNC: begin
          if (any_unit_active) stall_inc = 1'b1;
          else                 state_d   = IDLE;
        end
        default: ;
      endcase
    end
    stall_d  = (stall_inc && stall_q != CNT_MAX) ? stall_q + CNT_ONE : stall_q;
    issued_d = (issue_inc && issued_q != CNT_MAX) ? issued_q + CNT_ONE : issued_q;
  end

  // State, holding register, sticky flags and counters; reset overrides enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      stall_q   <= '0;
      issued_q  <= '0;
    end else if (enable) begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      stall_q   <= stall_d;
      issued_q  <= issued_d;
    end
  end

  assign weight_instr = instr_q;
  assign matmul_instr = instr_q;
  assign act_instr    = instr_q;
  assign halted       = halted_q;
  assign illegal_op   = illegal_q;
  assign stall_cycles = stall_q;
  assign issued_count = issued_q;
  assign busy         = (state_q != IDLE) | weight_resource_busy |
                        matmul_resource_busy | act_resource_busy;

endmodule
